// File: rtl/ramp_samp_adc.sv
// Single-channel ramp-and-sample ADC controller: drives the ramp, counts clocks
// until the synchronised comparator trips (or full-scale), then holds the result.
module ramp_samp_adc #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             comp_in,
    output logic             ramp_on,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             overflow,
    output logic             busy,
    output logic             done_pulse
);

    // A single-flop synchroniser is never safe, so shorter chains are widened to two.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] FULL_SCALE = {WIDTH{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_count;
    logic             r_valid;
    logic             r_overflow;
    logic             r_done_pulse;
    logic             r_comp_prev;

    logic             w_comp_s;
    logic             w_trip;
    logic             w_full;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_sync
            logic r_stage;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_stage <= 1'b0;
                    end else begin
                        r_stage <= comp_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_stage <= 1'b0;
                    end else begin
                        r_stage <= g_sync[gi-1].r_stage;
                    end
                end
            end
        end
    endgenerate

    assign w_comp_s = g_sync[STAGES-1].r_stage;

    // comp_prev tracks comp_s every cycle, so on the IDLE->RAMP edge it already
    // holds the level present at arming; a comparator high at start cannot trip.
    assign w_trip = (r_state == S_RAMP) && w_comp_s && !r_comp_prev;
    assign w_full = (r_cnt == FULL_SCALE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_overflow   <= 1'b0;
            r_done_pulse <= 1'b0;
            r_comp_prev  <= 1'b0;
        end else begin
            r_comp_prev  <= w_comp_s;
            r_done_pulse <= 1'b0;
            if (!run) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_count    <= '0;
                r_valid    <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_RAMP;
                        r_cnt   <= '0;
                    end
                    S_RAMP: begin
                        // Trip takes priority over full-scale in the same cycle.
                        if (w_trip) begin
                            r_count      <= r_cnt;
                            r_valid      <= 1'b1;
                            r_done_pulse <= 1'b1;
                            r_state      <= S_DONE;
                        end else if (w_full) begin
                            r_count      <= FULL_SCALE;
                            r_overflow   <= 1'b1;
                            r_valid      <= 1'b1;
                            r_done_pulse <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign ramp_on    = (r_state == S_RAMP);
    assign busy       = ramp_on;
    assign count      = r_count;
    assign valid      = r_valid;
    assign overflow   = r_overflow;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_ramp_samp_adc.sv
// Directed bench for ramp_samp_adc: conversions, overflow, abort, hold/re-arm, reset.
module tb_ramp_samp_adc;

    logic       clk;
    logic       reset;
    logic       run;
    logic       comp_in;
    logic       ramp_on;
    logic [7:0] count;
    logic       valid;
    logic       overflow;
    logic       busy;
    logic       done_pulse;

    int n_assert;
    int n_fail;

    ramp_samp_adc #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .comp_in    (comp_in),
        .ramp_on    (ramp_on),
        .count      (count),
        .valid      (valid),
        .overflow   (overflow),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ramp, input logic [7:0] e_cnt,
                           input logic e_vld, input logic e_ovf, input logic e_dp);
        chk({tag, ".ramp_on"},    {31'd0, ramp_on},    {31'd0, e_ramp});
        chk({tag, ".busy"},       {31'd0, busy},       {31'd0, e_ramp});
        chk({tag, ".count"},      {24'd0, count},      {24'd0, e_cnt});
        chk({tag, ".valid"},      {31'd0, valid},      {31'd0, e_vld});
        chk({tag, ".overflow"},   {31'd0, overflow},   {31'd0, e_ovf});
        chk({tag, ".done_pulse"}, {31'd0, done_pulse}, {31'd0, e_dp});
        $display("step %s: ramp_on=%0d count=%0d valid=%0d overflow=%0d done_pulse=%0d",
                 tag, ramp_on, count, valid, overflow, done_pulse);
    endtask

    int pulses;
    int count_changed;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        run      = 1'b0;
        comp_in  = 1'b0;
        tick(3);
        chk_all("reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Basic conversion: rise during the counter=40 cycle -> count 42.
        reset = 1'b0;
        run   = 1'b1;
        tick(1);
        chk_all("start", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(40);
        comp_in = 1'b1;
        tick(2);
        chk_all("basic_ramping", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("basic_done", 1'b0, 8'd42, 1'b1, 1'b0, 1'b1);
        tick(1);
        chk_all("basic_hold", 1'b0, 8'd42, 1'b1, 1'b0, 1'b0);

        // Hold: comparator activity while DONE must be ignored.
        pulses        = 0;
        count_changed = 0;
        for (int i = 0; i < 50; i++) begin
            comp_in = ~comp_in;
            tick(1);
            if (done_pulse) pulses++;
            if (count !== 8'd42 || valid !== 1'b1) count_changed++;
        end
        chk("hold_pulses", pulses, 0);
        chk("hold_changes", count_changed, 0);

        // Clear, then re-arm and abort at counter=100.
        run     = 1'b0;
        comp_in = 1'b0;
        tick(1);
        chk_all("clear", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(2);
        run = 1'b1;
        tick(1);
        chk_all("rearm", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(100);
        chk_all("abort_pre", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        run = 1'b0;
        tick(1);
        chk_all("abort", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("abort_after", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // New conversion after abort: trip at counter=10 -> count 12.
        run = 1'b1;
        tick(1);
        tick(10);
        comp_in = 1'b1;
        tick(3);
        chk_all("restart_done", 1'b0, 8'd12, 1'b1, 1'b0, 1'b1);

        // Comparator already high at start -> overflow at 255.
        run = 1'b0;
        tick(3);
        run = 1'b1;
        tick(1);
        tick(255);
        chk_all("high_start_last", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("high_start_ovf", 1'b0, 8'd255, 1'b1, 1'b1, 1'b1);

        // Plain overflow with comparator low.
        run     = 1'b0;
        comp_in = 1'b0;
        tick(3);
        run = 1'b1;
        tick(1);
        tick(255);
        chk_all("ovf_last", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("ovf_done", 1'b0, 8'd255, 1'b1, 1'b1, 1'b1);
        tick(1);
        chk_all("ovf_hold", 1'b0, 8'd255, 1'b1, 1'b1, 1'b0);

        // Trip lands exactly on the full-scale cycle: trip wins, no overflow.
        run = 1'b0;
        tick(3);
        run = 1'b1;
        tick(1);
        tick(253);
        comp_in = 1'b1;
        tick(3);
        chk_all("trip_at_full", 1'b0, 8'd255, 1'b1, 1'b0, 1'b1);

        // Synchronous reset mid-RAMP with run held high.
        run     = 1'b0;
        comp_in = 1'b0;
        tick(3);
        run = 1'b1;
        tick(1);
        tick(20);
        reset = 1'b1;
        tick(1);
        chk_all("reset_mid", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1);
        chk_all("reset_restart", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(5);
        comp_in = 1'b1;
        tick(3);
        chk_all("reset_conv", 1'b0, 8'd7, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
